// File: rtl/seg_pkg.sv
// Shared constants for the four-digit seven-segment scan controller.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_decode.sv
// BCD to active-low seven-segment decode; non-BCD codes light nothing.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup, no state.
    always_comb begin
        seg_o = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with per-slot dead time.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_OFF   | scan disabled, display dark, counters held at zero
//   ST_BLANK | first BLANK_CYC cycles of a slot, all anodes off
//   ST_DRIVE | remainder of the slot, anode of slot dig driven
//
// Inputs are snapshotted once per frame (enable and 3->0 wrap) so a frame
// never mixes old and new digits. Display outputs are registered and lag
// the scan state by one cycle; dropping en darkens them on the very next
// edge regardless of state.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 65536,
    parameter int BLANK_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  dig,
    output logic        frame_strobe
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    scan_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    dig_q;
    logic [15:0]   shd_digits_q;
    logic [3:0]    shd_dp_q;
    logic          shd_lz_q;
    logic          frame_strobe_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [3:0]    cur_bcd;
    logic [6:0]    cur_seg;
    logic          hide_slot;

    // Pick the shadow digit for the slot being scanned.
    always_comb begin
        cur_bcd = shd_digits_q[3:0];
        case (dig_q)
            2'd0: cur_bcd = shd_digits_q[3:0];
            2'd1: cur_bcd = shd_digits_q[7:4];
            2'd2: cur_bcd = shd_digits_q[11:8];
            2'd3: cur_bcd = shd_digits_q[15:12];
            default: cur_bcd = shd_digits_q[3:0];
        endcase
    end

    seg_decode u_decode (
        .bcd_i (cur_bcd),
        .seg_o (cur_seg)
    );

    // Leading-zero suppression only ever applies to the leftmost slot.
    assign hide_slot = shd_lz_q && (shd_digits_q[15:12] == 4'd0) && (dig_q == 2'd3);

    // Next display values from the current scan position; en low forces dark.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (en && (state_q == ST_DRIVE) && !hide_slot) begin
            an_d         = AN_OFF;
            an_d[dig_q]  = 1'b0;
            seg_d        = cur_seg;
            dp_d         = ~shd_dp_q[dig_q];
        end
    end

    // Scan FSM, slot counter, frame snapshot and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            cnt_q          <= '0;
            dig_q          <= 2'd0;
            shd_digits_q   <= 16'h0000;
            shd_dp_q       <= 4'h0;
            shd_lz_q       <= 1'b0;
            frame_strobe_q <= 1'b0;
            an_q           <= AN_OFF;
            seg_q          <= SEG_OFF;
            dp_q           <= 1'b1;
        end else begin
            frame_strobe_q <= 1'b0;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            if (!en) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
                dig_q   <= 2'd0;
            end else if (state_q == ST_OFF) begin
                state_q        <= ST_BLANK;
                cnt_q          <= '0;
                dig_q          <= 2'd0;
                shd_digits_q   <= digits;
                shd_dp_q       <= dp_mask;
                shd_lz_q       <= lz_blank;
                frame_strobe_q <= 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                state_q <= ST_BLANK;
                cnt_q   <= '0;
                dig_q   <= dig_q + 2'd1;
                if (dig_q == 2'd3) begin
                    shd_digits_q   <= digits;
                    shd_dp_q       <= dp_mask;
                    shd_lz_q       <= lz_blank;
                    frame_strobe_q <= 1'b1;
                end
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                state_q <= (cnt_q >= BLANK_LAST) ? ST_DRIVE : ST_BLANK;
            end
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign dig          = dig_q;
    assign frame_strobe = frame_strobe_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 65536: clock cycles per digit slot; legal range BLANK_CYC+1 .. 2^20.
REQ-002 Parameter BLANK_CYC, default 256: dead-time cycles at the start of each slot, all anodes off; legal range 1 .. SCAN_DIV-1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scan enable; low forces the display dark.
REQ-006 digits  input  16  four BCD digits, [3:0]=digit0 (rightmost) .. [15:12]=digit3 (leftmost).
REQ-007 dp_mask  input  4  active-high decimal-point request per digit, bit n = digit n.
REQ-008 lz_blank  input  1  high suppresses digit3 when its value is 0 (12-hour tens-of-hours).
REQ-009 an  output  4  active-low anode enables, bit n = digit n.
REQ-010 seg  output  7  active-low cathodes, seg[0]=a .. seg[6]=g.
REQ-011 dp  output  1  active-low decimal point.
REQ-012 dig  output  2  index of the digit slot currently scanned.
REQ-013 frame_strobe  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-014 Slot counter cnt runs 0..SCAN_DIV-1; at SCAN_DIV-1 it returns to 0 and dig increments, wrapping 3->0.
REQ-015 FSM states: OFF, BLANK, DRIVE; BLANK while cnt<BLANK_CYC, DRIVE while cnt>=BLANK_CYC, OFF while en=0.
REQ-016 OFF->BLANK on the first cycle en=1; that cycle loads cnt=0, dig=0 and takes a snapshot.
REQ-017 Any state->OFF on the first cycle en=0; that cycle clears cnt and dig to 0; an=4'hF from the next cycle.
REQ-018 Snapshot: digits, dp_mask, lz_blank are registered into shadow registers only on OFF->BLANK and on dig wrap 3->0; mid-frame input changes have no visible effect until the next frame.
REQ-019 frame_strobe is high for exactly the cycle in which a snapshot is taken; never high in OFF.
REQ-020 an, seg, dp are registered: they reflect the state/cnt/dig of the previous cycle (1-cycle latency).
REQ-021 In BLANK and OFF: an=4'hF, seg=7'h7F, dp=1.
REQ-022 In DRIVE: an has exactly one 0 bit, at position dig; seg = decode of shadow digit dig; dp = ~shadow dp_mask[dig].
REQ-023 Decode: 0-9 to standard seven-segment patterns (e.g. 0->7'h40, 1->7'h79, 8->7'h00); values 10-15 -> seg=7'h7F, anode still driven.
REQ-024 If shadow lz_blank=1 and shadow digit3=0, slot 3 behaves as BLANK for its full length (an=4'hF, dp=1).
REQ-025 an never has more than one bit low in any cycle, including across slot boundaries and en transitions.

Reset
REQ-026 rst_n low asynchronously forces: state=OFF, cnt=0, dig=0, shadows=0, an=4'hF, seg=7'h7F, dp=1, frame_strobe=0.
REQ-027 Reset deassertion is synchronised by the consumer; first active edge with en=1 behaves per REQ-016.
REQ-028 Reset asserted mid-slot takes effect immediately; no partial slot resumes.

Structure
REQ-029 Shared package seg_pkg holds the 7-bit pattern constants SEG_0..SEG_9, SEG_OFF and the FSM state enumeration.
REQ-030 BCD-to-segment decode is a separate sub-module seg_decode (combinational, 4-bit in, 7-bit active-low out); seg_scan_ctrl instantiates it once.
REQ-031 cnt width is clog2(SCAN_DIV); no other counters.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-032 Reset release, en=1, digits=16'h1234: frame_strobe at cycle 0; an=4'hF cycles 1-2, 4'hE with seg=SEG_4 cycles 3-8, 4'hF cycles 9-10, 4'hD with SEG_3 from 11; frame_strobe again at cycle 32.
REQ-033 Change digits to 16'h5678 at cycle 5 -> displayed values remain 1,2,3,4 until cycle 33, then 8,7,6,5.
REQ-034 lz_blank=1, digits=16'h0930 -> slot 3 an=4'hF throughout; slot 0 shows SEG_0; lz_blank=0 next frame -> slot 3 shows SEG_0.
REQ-035 en dropped mid-DRIVE of slot 2 -> an=4'hF next cycle, dig=0; en re-raised -> frame_strobe, slot 0 restarts with BLANK.
REQ-036 digits=16'hFA00, dp_mask=4'b0101 -> slots 3,2 drive anode with seg=7'h7F; dp=0 only in DRIVE of slots 0 and 2.
REQ-037 rst_n pulsed low mid-slot asynchronously -> an=4'hF, dig=0 before the next clock edge; assertion checks one-hot-low an every cycle.
